// File: rtl/timer_irq_sequencer_pkg.sv
// ============================================================================
// Module : timer_irq_sequencer_pkg
// Brief  : Shared FSM state type and TIFR bit indices for the timer IRQ path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_irq_sequencer_pkg;

  localparam int PC_WIDTH_DEF = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH_LO = 2'd1,
    PUSH_HI = 2'd2,
    JUMP    = 2'd3
  } irq_state_t;

  localparam logic [2:0] TOV0  = 3'd0;
  localparam logic [2:0] OCF0  = 3'd1;
  localparam logic [2:0] TOV1  = 3'd2;
  localparam logic [2:0] OCF1B = 3'd3;
  localparam logic [2:0] OCF1A = 3'd4;
  localparam logic [2:0] ICF1  = 3'd5;
  localparam logic [2:0] TOV2  = 3'd6;
  localparam logic [2:0] OCF2  = 3'd7;

endpackage

`default_nettype wire

// File: rtl/timer_irq_sequencer_prio_enc.sv
// ============================================================================
// Module : irq_priority_enc
// Brief  : Fixed-priority encoder (bit 7 highest) with vector address output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_priority_enc #(
  parameter int PC_WIDTH = 14,
  parameter int VEC_BASE = 6
) (
  input  logic [7:0]          pend,
  output logic                valid,
  output logic [2:0]          idx,
  output logic [PC_WIDTH-1:0] vec
);

  always_comb begin
    valid = |pend;
    idx   = 3'd0;
    // Ascending scan: the last (highest) set bit overrides lower ones.
    for (int i = 0; i < 8; i++) begin
      if (pend[i]) idx = 3'(i);
    end
  end

  // 2*(7-idx) == {~idx, 0}; vectors are two words apart.
  assign vec = PC_WIDTH'(VEC_BASE) + {{(PC_WIDTH-4){1'b0}}, ~idx, 1'b0};

endmodule

`default_nettype wire

// File: rtl/timer_irq_sequencer.sv
// ============================================================================
// Module : timer_irq_sequencer
// Brief  : Timer interrupt arbitration and entry sequencing (push PC, jump).
//          Optional IRQ_STATS_EN adds a 16-bit serviced-interrupt counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_irq_sequencer
  import timer_irq_sequencer_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int VEC_BASE = 6
) (
  input  logic                sysClock,
  input  logic                rst_n,
  input  logic [7:0]          TIFR_in,
  input  logic [7:0]          TIMSK_in,
  input  logic                sreg_i,
  input  logic                instr_boundary,
  input  logic [PC_WIDTH-1:0] pc_current,
  input  logic                push_ack,
  output logic                push_req,
  output logic [7:0]          push_data,
  output logic                hold,
  output logic                pc_overwrite,
  output logic [PC_WIDTH-1:0] pc_new,
  output logic [7:0]          tifr_clear,
  output logic                clear_i,
  output logic                irq_active,
  output logic [2:0]          irq_id
`ifdef IRQ_STATS_EN
  ,
  output logic [15:0]         irq_count
`endif
);

  irq_state_t          r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_vec;
  logic [15:0]         w_pc_ext;

  logic                w_valid;
  logic [2:0]          w_idx;
  logic [PC_WIDTH-1:0] w_vec;

  irq_priority_enc #(
    .PC_WIDTH (PC_WIDTH),
    .VEC_BASE (VEC_BASE)
  ) u_prio_enc (
    .pend  (TIFR_in & TIMSK_in),
    .valid (w_valid),
    .idx   (w_idx),
    .vec   (w_vec)
  );

  assign w_pc_ext = 16'(r_pc);

  // Outputs are registered alongside the state so they decode the new state.
  always_ff @(posedge sysClock or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc         <= '0;
      r_vec        <= '0;
      push_req     <= 1'b0;
      push_data    <= 8'h00;
      hold         <= 1'b0;
      pc_overwrite <= 1'b0;
      pc_new       <= '0;
      tifr_clear   <= 8'h00;
      clear_i      <= 1'b0;
      irq_active   <= 1'b0;
      irq_id       <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (instr_boundary && sreg_i && w_valid) begin
            r_state    <= PUSH_LO;
            r_pc       <= pc_current;
            r_vec      <= w_vec;
            irq_id     <= w_idx;
            push_req   <= 1'b1;
            push_data  <= pc_current[7:0];
            hold       <= 1'b1;
            irq_active <= 1'b1;
            clear_i    <= 1'b1;
          end
        end
        PUSH_LO: begin
          clear_i <= 1'b0;
          if (push_ack) begin
            r_state   <= PUSH_HI;
            push_data <= w_pc_ext[15:8];
          end
        end
        PUSH_HI: begin
          if (push_ack) begin
            r_state      <= JUMP;
            push_req     <= 1'b0;
            push_data    <= 8'h00;
            pc_overwrite <= 1'b1;
            pc_new       <= r_vec;
            tifr_clear   <= 8'b1 << irq_id;
          end
        end
        JUMP: begin
          r_state      <= IDLE;
          pc_overwrite <= 1'b0;
          tifr_clear   <= 8'h00;
          hold         <= 1'b0;
          irq_active   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef IRQ_STATS_EN
  always_ff @(posedge sysClock or negedge rst_n) begin
    if (!rst_n) begin
      irq_count <= 16'h0000;
    end else if (r_state == JUMP) begin
      irq_count <= irq_count + 16'h0001;
    end
  end
`endif

endmodule

`default_nettype wire
